// File: rtl/mod_cu.sv
// Control unit for the iterative repeated-subtraction MOD datapath.
// Sequences we/re/s from start and the datapath compare flag x; reports busy/done/err/iter_count.
module mod_cu #(
  parameter int unsigned      CNT_W    = 32,
  parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(32'hFFFF_FFFF)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             b_zero,
  input  logic             x,
  output logic             we,
  output logic             re,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    READ = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             at_max;

  assign at_max = (cnt_q == MAX_ITER);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Only we looks at x (and the saturation compare); every other strobe is pure state decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b_zero) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        we      = 1'b1;
        state_d = ITER;
      end
      ITER: begin
        if (x) begin
          state_d = READ;
        end else if (at_max) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s          = (state_q == ITER) || (state_q == READ);
  assign re         = (state_q == READ);
  assign busy       = (state_q == LOAD) || (state_q == ITER) || (state_q == READ);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign iter_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu: behavioural datapath beside the DUT, expectations from plain division/modulo.
module tb_mod_cu;

  localparam int MAXI = 4;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        b_zero;
  logic        x;
  logic        we, re, s, busy, done, err;
  logic [31:0] iter_count;
  logic [2:0]  dbg_state;

  logic [31:0] a_val, b_val, temp, result;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  typedef struct {
    int   lat;
    int   we_n;
    int   we_first;
    int   we_last;
    int   re_cyc;
    logic got_done;
    logic got_err;
    logic both;
    logic timed_out;
    logic post_done;
    logic post_busy;
  } op_t;

  mod_cu #(.CNT_W(32), .MAX_ITER(32'd4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .b_zero     (b_zero),
    .x          (x),
    .we         (we),
    .re         (re),
    .s          (s),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .iter_count (iter_count),
    .dbg_state  (dbg_state)
  );

  // Clock and behavioural datapath
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign x = (temp < b_val);

  always @(posedge CLK) begin
    if (we) temp <= s ? (temp - b_val) : a_val;
    if (re) result <= temp;
  end

  // Driver: launch one op at a negedge, collect what happens until done/err.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bz,
                       input int poke, output op_t r);
    int   cyc;
    logic fin;
    r = '{default: 0};
    fin = 1'b0;
    a_val = a; b_val = b; b_zero = bz; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 80) begin
      if (we) begin
        r.we_n++;
        if (r.we_first == 0) r.we_first = cyc;
        r.we_last = cyc;
      end
      if (re) r.re_cyc = cyc;
      if (done && err) r.both = 1'b1;
      if (done) begin r.got_done = 1'b1; r.lat = cyc; fin = 1'b1; end
      if (err && !r.got_err) begin r.got_err = 1'b1; r.lat = cyc; fin = 1'b1; end
      if (!fin) begin
        start = (cyc == poke);
        @(negedge CLK);
        cyc++;
      end
    end
    r.timed_out = !fin;
    start = 1'b0;
    @(negedge CLK);
    r.post_done = done;
    r.post_busy = busy;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({we, re, s, busy, done, err, iter_count} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we%b re%b s%b busy%b done%b err%b cnt%0d, want all 0",
               we, re, s, busy, done, err, iter_count);
    end
  endtask

  task automatic test_basic();
    op_t r;
    do_op(32'd17, 32'd5, 1'b0, -1, r);
    n_checks++;
    if (r.timed_out || !r.got_done || r.lat !== 7 || r.re_cyc !== 6) begin
      n_fail++;
      $display("FAIL basic_timing: got to%b done%b lat%0d re%0d, want done at 7 re at 6",
               r.timed_out, r.got_done, r.lat, r.re_cyc);
    end
    n_checks++;
    if (r.we_n !== 4 || r.we_first !== 1 || r.we_last !== 4) begin
      n_fail++;
      $display("FAIL basic_we: got n%0d first%0d last%0d, want 4 writes cycles 1..4",
               r.we_n, r.we_first, r.we_last);
    end
    n_checks++;
    if (iter_count !== 32'd3 || result !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_result: got cnt%0d res%0d, want 3 and 2", iter_count, result);
    end
  endtask

  task automatic test_a_lt_b();
    op_t r;
    do_op(32'd3, 32'd7, 1'b0, -1, r);
    n_checks++;
    if (!r.got_done || r.lat !== 4 || r.we_n !== 1 || iter_count !== 32'd0 || result !== 32'd3) begin
      n_fail++;
      $display("FAIL a_lt_b: got done%b lat%0d we%0d cnt%0d res%0d, want 1 4 1 0 3",
               r.got_done, r.lat, r.we_n, iter_count, result);
    end
  endtask

  task automatic test_b_zero();
    op_t r;
    do_op(32'd40, 32'd0, 1'b1, -1, r);
    n_checks++;
    if (!r.got_err || r.lat !== 1 || r.we_n !== 0 || r.re_cyc !== 0 || r.got_done || r.post_done) begin
      n_fail++;
      $display("FAIL b_zero: got err%b lat%0d we%0d re%0d done%b/%b, want err at 1, no strobes",
               r.got_err, r.lat, r.we_n, r.re_cyc, r.got_done, r.post_done);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: got err%b busy%b, want 1 0", err, busy);
    end
    do_op(32'd9, 32'd4, 1'b0, -1, r);
    n_checks++;
    if (!r.got_done || r.got_err || err !== 1'b0 || result !== 32'd1 || iter_count !== 32'd2) begin
      n_fail++;
      $display("FAIL err_clear: got done%b err%b/%b res%0d cnt%0d, want 1 0 0 1 2",
               r.got_done, r.got_err, err, result, iter_count);
    end
  endtask

  task automatic test_timeout();
    op_t r;
    do_op(32'd100, 32'd1, 1'b0, -1, r);
    n_checks++;
    if (!r.got_err || r.got_done || r.post_done || r.lat !== MAXI + 3 || r.we_n !== MAXI + 1
        || iter_count !== 32'(MAXI)) begin
      n_fail++;
      $display("FAIL timeout: got err%b done%b/%b lat%0d we%0d cnt%0d, want err at %0d, %0d writes, cnt %0d",
               r.got_err, r.got_done, r.post_done, r.lat, r.we_n, iter_count, MAXI + 3, MAXI + 1, MAXI);
    end
    repeat (2) @(negedge CLK);
    n_checks++;
    if (err !== 1'b1 || iter_count !== 32'(MAXI)) begin
      n_fail++;
      $display("FAIL timeout_hold: got err%b cnt%0d, want 1 %0d", err, iter_count, MAXI);
    end
  endtask

  // Scoreboard: expected remainder queued by the model before the op runs.
  task automatic test_random();
    op_t         r;
    logic [31:0] a, b, n, exp_res;
    logic        to;
    for (int i = 0; i < 24; i++) begin
      b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(5 * b, 40 * b));
      else                           a = 32'($urandom_range(0, 5 * b - 1));
      n  = a / b;
      to = (n > MAXI);
      exp_q.push_back(a % b);
      do_op(a, b, 1'b0, -1, r);
      exp_res = exp_q.pop_front();
      n_checks++;
      if (to) begin
        if (!r.got_err || r.got_done || r.lat !== MAXI + 3 || r.we_n !== MAXI + 1
            || iter_count !== 32'(MAXI)) begin
          n_fail++;
          $display("FAIL rand_timeout a=%0d b=%0d: got err%b done%b lat%0d we%0d cnt%0d",
                   a, b, r.got_err, r.got_done, r.lat, r.we_n, iter_count);
        end
      end else begin
        if (!r.got_done || r.got_err || r.both || r.lat !== int'(n) + 4 || r.we_n !== int'(n) + 1
            || r.re_cyc !== int'(n) + 3 || iter_count !== n || result !== exp_res) begin
          n_fail++;
          $display("FAIL rand_op a=%0d b=%0d: got done%b err%b lat%0d we%0d re%0d cnt%0d res%0d, want lat%0d we%0d cnt%0d res%0d",
                   a, b, r.got_done, r.got_err, r.lat, r.we_n, r.re_cyc, iter_count, result,
                   n + 4, n + 1, n, exp_res);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    op_t r;
    a_val = 32'd17; b_val = 32'd5; b_zero = 1'b0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({we, re, s, busy, done, err, iter_count} !== 38'd0) begin
      n_fail++;
      $display("FAIL async_reset_iter: got we%b s%b busy%b cnt%0d, want all 0",
               we, s, busy, iter_count);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset_idle: got busy%b state%0d, want 0 0", busy, dbg_state);
    end
    do_op(32'd17, 32'd5, 1'b0, -1, r);
    n_checks++;
    if (!r.got_done || r.lat !== 7 || iter_count !== 32'd3 || result !== 32'd2) begin
      n_fail++;
      $display("FAIL async_reset_rerun: got done%b lat%0d cnt%0d res%0d, want 1 7 3 2",
               r.got_done, r.lat, iter_count, result);
    end
    do_op(32'd1, 32'd0, 1'b1, -1, r);
    #3 RST_N = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_err: got err%b, want 0", err);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_start_ignored();
    op_t r;
    do_op(32'd17, 32'd5, 1'b0, 3, r);
    n_checks++;
    if (!r.got_done || r.lat !== 7 || r.we_n !== 4 || result !== 32'd2 || r.post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got done%b lat%0d we%0d res%0d busy%b, want 1 7 4 2 0",
               r.got_done, r.lat, r.we_n, result, r.post_busy);
    end
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: got busy%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_cyc;
    int last_cyc;
    int gap_bad;
    a_val = 32'd10; b_val = 32'd3; b_zero = 1'b0; start = 1'b1;
    pulses = 0; first_cyc = 0; last_cyc = 0; gap_bad = 0;
    @(negedge CLK);
    for (int cyc = 1; cyc < 60 && pulses < 3; cyc++) begin
      if (done) begin
        if (pulses == 0) first_cyc = cyc;
        else if (cyc - last_cyc != 8) gap_bad++;
        last_cyc = cyc;
        pulses++;
        if (pulses == 3) start = 1'b0;
      end
      if (pulses < 3) @(negedge CLK);
    end
    start = 1'b0;
    n_checks++;
    if (pulses !== 3 || first_cyc !== 7 || gap_bad !== 0 || result !== 32'd1) begin
      n_fail++;
      $display("FAIL back_to_back: got pulses%0d first%0d badgaps%0d res%0d, want 3 7 0 1",
               pulses, first_cyc, gap_bad, result);
    end
    repeat (2) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_stop: got busy%b done%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N  = 1'b0;
    start  = 1'b0;
    b_zero = 1'b0;
    a_val  = '0;
    b_val  = 32'd1;
    temp   = '0;
    result = '0;
    repeat (2) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    @(negedge CLK);
    test_basic();
    test_a_lt_b();
    test_b_zero();
    test_timeout();
    test_random();
    test_async_reset();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
